// File: rtl/mcu_encode_scheduler.sv
// rtl/mcu_encode_scheduler.sv - MCU block sequencer feeding zig-zag coefficients to huffman_encoder
`timescale 1ns/1ps

module mcu_encode_scheduler #(
  parameter int MCU_PER_FRAME = 1200,
  parameter int SAMPLING      = 0,
  parameter int MIN_GAP       = 48
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               frame_start,
  input  logic               blk_ready,
  output logic               blk_rd_en,
  output logic        [5:0]  blk_rd_addr,
  input  logic signed [11:0] blk_rd_data,
  output logic               blk_release,
  input  logic               enc_idle,
  output logic signed [11:0] ZigZag_data,
  output logic               start_encoder,
  output logic        [1:0]  data_state,
  output logic               dc_clr,
  output logic               busy,
  output logic               frame_done,
  output logic        [15:0] mcu_idx
);

  // Blocks per MCU: 4:2:0 -> 6, 4:2:2 -> 4, 4:4:4 -> 3; the last two are always Cb, Cr.
  localparam int NBLK = (SAMPLING == 0) ? 6 : (SAMPLING == 1) ? 4 : 3;
  localparam int NY   = NBLK - 2;
  localparam logic [2:0]  LAST_BLK = 3'(NBLK - 1);
  localparam logic [15:0] LAST_MCU = 16'(MCU_PER_FRAME - 1);
  // Leaving GAP at this count puts the next first coefficient MIN_GAP+2 cycles after
  // the last one: the exit cycle, one WAIT_BLK cycle, the address cycle, the register stage.
  localparam logic [15:0] GAP_EXIT = (MIN_GAP > 3) ? 16'(MIN_GAP - 2) : 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BLK, S_READ, S_GAP} state_t;

  state_t              r_state;
  logic                r_rd_en;
  logic         [5:0]  r_rd_addr;
  logic                r_vld;
  logic signed  [11:0] r_zz;
  logic                r_se;
  logic         [1:0]  r_ds;
  logic                r_rel;
  logic                r_dcc;
  logic                r_busy;
  logic                r_fd;
  logic         [15:0] r_mcu;
  logic         [2:0]  r_blk;
  logic         [15:0] r_gap;

  logic [1:0] w_comp;
  logic       w_last_coef;
  logic       w_gap_done;

  // Component code for the block about to be read.
  always_comb begin
    w_comp = 2'd3;
    if (r_blk < 3'(NY)) begin
      w_comp = 2'd1;
    end else if (r_blk == 3'(NY)) begin
      w_comp = 2'd2;
    end
  end

  // Last coefficient is on the bus when the stage is full but nothing follows it.
  assign w_last_coef = r_se & ~r_vld;
  assign w_gap_done  = (r_gap >= GAP_EXIT) & enc_idle;

  // Register stage: buffer data valid one cycle after the read strobe is passed to the encoder.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_vld <= 1'b0;
      r_zz  <= '0;
      r_se  <= 1'b0;
    end else begin
      r_vld <= r_rd_en;
      r_se  <= r_vld;
      r_zz  <= r_vld ? blk_rd_data : 12'sd0;
    end
  end

  // Block/MCU sequencing FSM with registered strobes and status.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_ds      <= '0;
      r_rel     <= 1'b0;
      r_dcc     <= 1'b0;
      r_busy    <= 1'b0;
      r_fd      <= 1'b0;
      r_mcu     <= '0;
      r_blk     <= '0;
      r_gap     <= '0;
    end else begin
      r_dcc <= 1'b0;
      r_rel <= 1'b0;
      r_fd  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with frame_done belongs to the frame just finished.
          if (frame_start && !r_fd) begin
            r_dcc   <= 1'b1;
            r_busy  <= 1'b1;
            r_mcu   <= '0;
            r_blk   <= '0;
            r_state <= S_WAIT_BLK;
          end
        end
        S_WAIT_BLK: begin
          if (blk_ready && enc_idle) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          if (r_rd_en) begin
            if (r_rd_addr == 6'd0) begin
              r_ds <= w_comp;
            end
            if (r_rd_addr == 6'd63) begin
              r_rd_en   <= 1'b0;
              r_rd_addr <= '0;
            end else begin
              r_rd_addr <= r_rd_addr + 6'd1;
            end
          end
          if (w_last_coef) begin
            r_rel   <= 1'b1;
            r_ds    <= '0;
            r_gap   <= 16'd1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap != 16'hFFFF) begin
            r_gap <= r_gap + 16'd1;
          end
          if (w_gap_done) begin
            if (r_blk != LAST_BLK) begin
              r_blk   <= r_blk + 3'd1;
              r_state <= S_WAIT_BLK;
            end else if (r_mcu != LAST_MCU) begin
              r_mcu   <= r_mcu + 16'd1;
              r_blk   <= '0;
              r_state <= S_WAIT_BLK;
            end else begin
              r_fd    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign blk_rd_en     = r_rd_en;
  assign blk_rd_addr   = r_rd_addr;
  assign blk_release   = r_rel;
  assign ZigZag_data   = r_zz;
  assign start_encoder = r_se;
  assign data_state    = r_ds;
  assign dc_clr        = r_dcc;
  assign busy          = r_busy;
  assign frame_done    = r_fd;
  assign mcu_idx       = r_mcu;

endmodule
